// File: rtl/fft_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fft_stage_ctrl
// Description : Address sequencer for an in-place radix-2 DIF FFT over a
//               dual-port ping-pong RAM. For each of LOG_S stages it issues
//               every butterfly read pair with its twiddle index, replays the
//               pairs LAT cycles later as write-back pairs, flips the bank
//               select between stages and pulses done at the end.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               start           - run request, honoured only when idle
//               busy, done      - run in progress / end-of-transform pulse
//               stage           - current stage index
//               ram_select      - ping-pong bank select
//               rd_valid, rd_addr_0, rd_addr_1, twiddle - read side
//               wr_en, wr_addr_0, wr_addr_1             - write-back side
// Revision    : 1.0 - initial release
// ============================================================================
module fft_stage_ctrl #(
    parameter int SIZE  = 1024,
    parameter int LOG_S = 10,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [LOG_S-1:0] stage,
    output logic             ram_select,
    output logic             rd_valid,
    output logic [LOG_S-1:0] rd_addr_0,
    output logic [LOG_S-1:0] rd_addr_1,
    output logic [LOG_S-2:0] twiddle,
    output logic             wr_en,
    output logic [LOG_S-1:0] wr_addr_0,
    output logic [LOG_S-1:0] wr_addr_1
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int               c_DW         = $clog2(LAT + 1);
    localparam logic [LOG_S-2:0] c_K_LAST     = (LOG_S-1)'(SIZE / 2 - 1);
    localparam logic [LOG_S-1:0] c_STAGE_LAST = LOG_S'(LOG_S - 1);
    localparam logic [c_DW-1:0]  c_DRAIN_INIT = c_DW'(LAT);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [LOG_S-2:0] r_k;
    logic [LOG_S-1:0] r_stage;
    logic             r_ram_sel;
    logic [c_DW-1:0]  r_drain;

    logic             r_pipe_v  [LAT];
    logic [LOG_S-1:0] r_pipe_a0 [LAT];
    logic [LOG_S-1:0] r_pipe_a1 [LAT];

    logic             w_rd_valid;
    logic [LOG_S-1:0] w_b;
    logic [LOG_S-1:0] w_k_ext;
    logic [LOG_S-1:0] w_low_mask;
    logic [LOG_S-1:0] w_low;
    logic [LOG_S-1:0] w_addr_0;
    logic [LOG_S-1:0] w_addr_1;
    logic [LOG_S-2:0] w_twiddle;

    // ------------------------------------------------------------------
    // Butterfly address generation. b is the half-span of the current
    // stage: k's low b bits select the element within a group, the
    // remaining bits select the group, and the pair straddles bit b.
    // ------------------------------------------------------------------
    assign w_rd_valid = (r_state == S_RUN);
    assign w_b        = c_STAGE_LAST - r_stage;
    assign w_k_ext    = {1'b0, r_k};
    assign w_low_mask = (LOG_S'(1) << w_b) - LOG_S'(1);
    assign w_low      = w_k_ext & w_low_mask;
    assign w_addr_0   = ((w_k_ext >> w_b) << (w_b + LOG_S'(1))) | w_low;
    assign w_addr_1   = w_addr_0 | (LOG_S'(1) << w_b);
    // w_low < 2**b <= 2**(LOG_S-1), so dropping its top bit loses nothing;
    // the narrow shift then truncates the twiddle index naturally.
    assign w_twiddle  = w_low[LOG_S-2:0] << r_stage;

    // Addresses are forced to zero outside RUN so idle outputs read as 0
    // and the write pipe carries clean zeros behind the last valid pair.
    assign rd_valid   = w_rd_valid;
    assign rd_addr_0  = w_rd_valid ? w_addr_0  : '0;
    assign rd_addr_1  = w_rd_valid ? w_addr_1  : '0;
    assign twiddle    = w_rd_valid ? w_twiddle : '0;

    assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done       = (r_state == S_DONE);
    assign stage      = r_stage;
    assign ram_select = r_ram_sel;
    assign wr_en      = r_pipe_v[LAT-1];
    assign wr_addr_0  = r_pipe_a0[LAT-1];
    assign wr_addr_1  = r_pipe_a1[LAT-1];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (r_k == c_K_LAST) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_drain == c_DW'(1)) begin
                    w_state_nxt = (r_stage == c_STAGE_LAST) ? S_DONE : S_RUN;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters and bank select. The bank flips only on the last DRAIN
    // cycle, after the final write of the stage has been issued.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k       <= '0;
            r_stage   <= '0;
            r_ram_sel <= 1'b0;
            r_drain   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_k       <= '0;
                        r_stage   <= '0;
                        r_ram_sel <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (r_k == c_K_LAST) begin
                        r_drain <= c_DRAIN_INIT;
                    end else begin
                        r_k <= r_k + (LOG_S-1)'(1);
                    end
                end
                S_DRAIN: begin
                    r_drain <= r_drain - c_DW'(1);
                    if (r_drain == c_DW'(1)) begin
                        r_ram_sel <= ~r_ram_sel;
                        r_k       <= '0;
                        if (r_stage != c_STAGE_LAST) begin
                            r_stage <= r_stage + LOG_S'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write-back delay line: read pairs re-emerge LAT cycles later.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                r_pipe_v[i]  <= 1'b0;
                r_pipe_a0[i] <= '0;
                r_pipe_a1[i] <= '0;
            end
        end else begin
            r_pipe_v[0]  <= w_rd_valid;
            r_pipe_a0[0] <= rd_addr_0;
            r_pipe_a1[0] <= rd_addr_1;
            for (int i = 1; i < LAT; i++) begin
                r_pipe_v[i]  <= r_pipe_v[i-1];
                r_pipe_a0[i] <= r_pipe_a0[i-1];
                r_pipe_a1[i] <= r_pipe_a1[i-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_stage_ctrl
// Description : Scoreboard bench for fft_stage_ctrl. Instance A uses
//               SIZE=8/LOG_S=3/LAT=2, instance B uses SIZE=16/LOG_S=4/LAT=1.
//               Each accepted start pushes the full expected read/write pair
//               sequence (built from group/span arithmetic) and the expected
//               done cycle; negedge monitors pop and compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_stage_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A: SIZE=8, LOG_S=3, LAT=2 ----------------
    logic       rst_a, start_a, busy_a, done_a, ram_select_a, rd_valid_a, wr_en_a;
    logic [2:0] stage_a, rd_addr_0_a, rd_addr_1_a, wr_addr_0_a, wr_addr_1_a;
    logic [1:0] twiddle_a;

    fft_stage_ctrl #(.SIZE(8), .LOG_S(3), .LAT(2)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
        .stage(stage_a), .ram_select(ram_select_a), .rd_valid(rd_valid_a),
        .rd_addr_0(rd_addr_0_a), .rd_addr_1(rd_addr_1_a), .twiddle(twiddle_a),
        .wr_en(wr_en_a), .wr_addr_0(wr_addr_0_a), .wr_addr_1(wr_addr_1_a)
    );

    // ---------------- instance B: SIZE=16, LOG_S=4, LAT=1 ---------------
    logic       rst_b, start_b, busy_b, done_b, ram_select_b, rd_valid_b, wr_en_b;
    logic [3:0] stage_b, rd_addr_0_b, rd_addr_1_b, wr_addr_0_b, wr_addr_1_b;
    logic [2:0] twiddle_b;

    fft_stage_ctrl #(.SIZE(16), .LOG_S(4), .LAT(1)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
        .stage(stage_b), .ram_select(ram_select_b), .rd_valid(rd_valid_b),
        .rd_addr_0(rd_addr_0_b), .rd_addr_1(rd_addr_1_b), .twiddle(twiddle_b),
        .wr_en(wr_en_b), .wr_addr_0(wr_addr_0_b), .wr_addr_1(wr_addr_1_b)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    logic [39:0] rdq_a[$], wrq_a[$], rdq_b[$], wrq_b[$];
    int          doneq_a[$], doneq_b[$];
    int          lo[2], hi[2];
    logic        rs_prev[2], rs_idle[2];
    int          cov_b[4][16];
    logic [39:0] it_a, it_b;

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [39:0] mk(input int s, input int rs, input int a0, input int a1, input int tw);
        return {8'(s), 8'(rs), 8'(a0), 8'(a1), 8'(tw)};
    endfunction

    function automatic bit model_idle(input int id);
        return (cyc < lo[id]) || (cyc > hi[id] + 1);
    endfunction

    // Expected transform: stage s pairs elements span=SIZE>>(s+1) apart,
    // groups of 2*span ascending, element j within a group uses twiddle
    // j*2**s. Bank select during stage s is s mod 2.
    task automatic push_run(input int id, input int c0);
        int sz, lg, lt, span;
        sz = (id == 0) ? 8 : 16;
        lg = (id == 0) ? 3 : 4;
        lt = (id == 0) ? 2 : 1;
        for (int s = 0; s < lg; s++) begin
            span = sz >> (s + 1);
            for (int base = 0; base < sz; base += 2 * span) begin
                for (int j = 0; j < span; j++) begin
                    if (id == 0) begin
                        rdq_a.push_back(mk(s, s % 2, base + j, base + j + span, j * (1 << s)));
                        wrq_a.push_back(mk(s, s % 2, base + j, base + j + span, 0));
                    end else begin
                        rdq_b.push_back(mk(s, s % 2, base + j, base + j + span, j * (1 << s)));
                        wrq_b.push_back(mk(s, s % 2, base + j, base + j + span, 0));
                    end
                end
            end
        end
        if (id == 0) doneq_a.push_back(c0 + 1 + lg * (sz / 2 + lt));
        else         doneq_b.push_back(c0 + 1 + lg * (sz / 2 + lt));
        lo[id]      = c0 + 1;
        hi[id]      = c0 + lg * (sz / 2 + lt);
        rs_prev[id] = rs_idle[id];
        rs_idle[id] = lg[0];
    endtask

    task automatic flush(input int id);
        if (id == 0) begin
            rdq_a.delete(); wrq_a.delete(); doneq_a.delete();
        end else begin
            rdq_b.delete(); wrq_b.delete(); doneq_b.delete();
            for (int s = 0; s < 4; s++) for (int a = 0; a < 16; a++) cov_b[s][a] = 0;
        end
        lo[id] = -10; hi[id] = -10;
        rs_prev[id] = 1'b0; rs_idle[id] = 1'b0;
    endtask

    // One clock of stimulus; called at posedge+1.
    task automatic step(input bit s0, input bit r0, input bit s1, input bit r1);
        start_a = s0; rst_a = r0; start_b = s1; rst_b = r1;
        if (s0 && !r0 && model_idle(0)) push_run(0, cyc);
        if (s1 && !r1 && model_idle(1)) push_run(1, cyc);
        @(posedge clk); #1;
        if (r0) flush(0);
        if (r1) flush(1);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_valid_a) begin
                it_a = mk(int'(stage_a), int'(ram_select_a), int'(rd_addr_0_a), int'(rd_addr_1_a), int'(twiddle_a));
                if (rdq_a.size() == 0) chk("rd_a_extra", 40'(rd_valid_a), 40'd0);
                else chk("rd_a", it_a, rdq_a.pop_front());
            end
            if (wr_en_a) begin
                it_a = mk(int'(stage_a), int'(ram_select_a), int'(wr_addr_0_a), int'(wr_addr_1_a), 0);
                if (wrq_a.size() == 0) chk("wr_a_extra", 40'(wr_en_a), 40'd0);
                else chk("wr_a", it_a, wrq_a.pop_front());
            end
            if (done_a) begin
                if (doneq_a.size() == 0) chk("done_a_extra", 40'(done_a), 40'd0);
                else chk("done_a_cycle", 40'(cyc), 40'(doneq_a.pop_front()));
            end
            chk("busy_a", 40'(busy_a), 40'(cyc >= lo[0] && cyc <= hi[0]));
            if (cyc < lo[0] || cyc > hi[0])
                chk("rsel_a", 40'(ram_select_a), 40'((cyc < lo[0]) ? rs_prev[0] : rs_idle[0]));
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_valid_b) begin
                it_b = mk(int'(stage_b), int'(ram_select_b), int'(rd_addr_0_b), int'(rd_addr_1_b), int'(twiddle_b));
                if (rdq_b.size() == 0) chk("rd_b_extra", 40'(rd_valid_b), 40'd0);
                else chk("rd_b", it_b, rdq_b.pop_front());
            end
            if (wr_en_b) begin
                it_b = mk(int'(stage_b), int'(ram_select_b), int'(wr_addr_0_b), int'(wr_addr_1_b), 0);
                if (wrq_b.size() == 0) chk("wr_b_extra", 40'(wr_en_b), 40'd0);
                else chk("wr_b", it_b, wrq_b.pop_front());
                cov_b[stage_b[1:0]][wr_addr_0_b]++;
                cov_b[stage_b[1:0]][wr_addr_1_b]++;
            end
            if (done_b) begin
                int bad;
                bad = 0;
                for (int s = 0; s < 4; s++) for (int a = 0; a < 16; a++) begin
                    if (cov_b[s][a] != 1) bad++;
                    cov_b[s][a] = 0;
                end
                chk("cover_b_once_per_stage", 40'(bad), 40'd0);
                if (doneq_b.size() == 0) chk("done_b_extra", 40'(done_b), 40'd0);
                else chk("done_b_cycle", 40'(cyc), 40'(doneq_b.pop_front()));
            end
            chk("busy_b", 40'(busy_b), 40'(cyc >= lo[1] && cyc <= hi[1]));
            if (cyc < lo[1] || cyc > hi[1])
                chk("rsel_b", 40'(ram_select_b), 40'((cyc < lo[1]) ? rs_prev[1] : rs_idle[1]));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int c;
        flush(0);
        flush(1);
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        @(posedge clk); #1;
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);

        // Reset values
        chk("rst_busy",  40'(busy_a),       40'd0);
        chk("rst_done",  40'(done_a),       40'd0);
        chk("rst_stage", 40'(stage_a),      40'd0);
        chk("rst_rsel",  40'(ram_select_a), 40'd0);
        chk("rst_rdv",   40'(rd_valid_a),   40'd0);
        chk("rst_rda0",  40'(rd_addr_0_a),  40'd0);
        chk("rst_rda1",  40'(rd_addr_1_a),  40'd0);
        chk("rst_tw",    40'(twiddle_a),    40'd0);
        chk("rst_wren",  40'(wr_en_a),      40'd0);
        chk("rst_wra0",  40'(wr_addr_0_a),  40'd0);
        chk("rst_wra1",  40'(wr_addr_1_a),  40'd0);
        chk("rst_b_rda1", 40'(rd_addr_1_b), 40'd0);
        mon_en = 1'b1;

        // Single start on both instances, run to completion
        step(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (45) step(1'b0, 1'b0, 1'b0, 1'b0);

        // start held high through a whole run and into the following IDLE
        repeat (21) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (25) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Abort at stage 1, k = 2
        c = cyc;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        while (cyc < c + 9) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_point_stage", 40'(stage_a), 40'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("abort_busy",  40'(busy_a),       40'd0);
        chk("abort_stage", 40'(stage_a),      40'd0);
        chk("abort_rsel",  40'(ram_select_a), 40'd0);
        chk("abort_wren",  40'(wr_en_a),      40'd0);
        chk("abort_wra0",  40'(wr_addr_0_a),  40'd0);
        chk("abort_rdv",   40'(rd_valid_a),   40'd0);
        repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (25) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized starts (often while busy) and occasional resets
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 6) == 0, ($urandom % 250) == 0,
                 ($urandom % 6) == 0, ($urandom % 250) == 0);
        end
        repeat (60) step(1'b0, 1'b0, 1'b0, 1'b0);

        chk("rdq_a_left",   40'(rdq_a.size()),   40'd0);
        chk("wrq_a_left",   40'(wrq_a.size()),   40'd0);
        chk("doneq_a_left", 40'(doneq_a.size()), 40'd0);
        chk("rdq_b_left",   40'(rdq_b.size()),   40'd0);
        chk("wrq_b_left",   40'(wrq_b.size()),   40'd0);
        chk("doneq_b_left", 40'(doneq_b.size()), 40'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
